// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational 32-bit ALU between two requesters:
//   port 0 - execute stage
//   port 1 - branch / auxiliary unit
//
// A request is accepted in IDLE (valid && ready), its operands are registered
// onto the ALU inputs, the ALU result and flags are captured one cycle later,
// and the captured values are returned on a valid/ready response channel
// tagged with the requester id. Only one operation is in flight at a time, so
// an operation occupies at least three cycles (IDLE accept, EXEC, RESP).
//
// Parameters
//   RR_EN       1 = round-robin between ports on contention
//               0 = fixed priority, port 0 always wins
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   req0_* / req1_*               request channels: valid, ready (out),
//                                 op1, op2, 4-bit field {funct7[5]/0, funct3}
//   alu_op1/alu_op2/alu_field     registered operands driven to the ALU
//   alu_result, alu_flags         ALU outputs, flags = {carry, overflow,
//                                 sign, zero}
//   rsp_valid, rsp_ready          response handshake
//   rsp_id                        requester id (meaningful while rsp_valid)
//   rsp_result, rsp_flags         captured ALU outputs
//   rsp_err                       the accepted field code was illegal
//   busy                          an operation is in flight (not IDLE)
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   input  logic [3:0]  req0_field,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   input  logic [3:0]  req1_field,

   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [3:0]  alu_field,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_flags,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] alu_op1_q, alu_op1_d;
   logic [31:0] alu_op2_q, alu_op2_d;
   logic [3:0]  alu_field_q, alu_field_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic [3:0]  rsp_flags_q, rsp_flags_d;
   logic        rsp_err_q, rsp_err_d;

   logic        both_valid;
   logic        any_valid;
   logic        win_id;
   logic        grant;

   // Field codes the ALU implements: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA,
   // SLT, SLTU. Anything else is sequenced normally but reported as an error.
   function automatic logic field_is_legal(input logic [3:0] field);
      case (field)
         4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
         4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

   // -------------------------------------------------------------------------
   // Winner selection. Depends only on the request valids, the grant history
   // and the state, so ready never combinationally depends on rsp_ready.
   // -------------------------------------------------------------------------
   always_comb begin : arbitrate
      both_valid = req0_valid && req1_valid;
      any_valid  = req0_valid || req1_valid;
      win_id     = 1'b0;
      if (both_valid) begin
         // Round-robin favours the port that did not win last time.
         win_id = RR_EN ? ~last_grant_q : 1'b0;
      end else if (req1_valid) begin
         win_id = 1'b1;
      end
      grant = (state_q == ST_IDLE) && any_valid;
   end

   assign req0_ready = grant && !win_id;
   assign req1_ready = grant &&  win_id;

   // -------------------------------------------------------------------------
   // Next-state and datapath update.
   // -------------------------------------------------------------------------
   always_comb begin : next_state
      // NOTE: every signal gets its hold value first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_op1_d    = alu_op1_q;
      alu_op2_d    = alu_op2_q;
      alu_field_d  = alu_field_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               alu_op1_d    = win_id ? req1_op1   : req0_op1;
               alu_op2_d    = win_id ? req1_op2   : req0_op2;
               alu_field_d  = win_id ? req1_field : req0_field;
               rsp_id_d     = win_id;
               last_grant_d = win_id;
               state_d      = ST_EXEC;
            end
         end

         ST_EXEC: begin
            // The ALU is looking at the registered operands this cycle.
            if (field_is_legal(alu_field_q)) begin
               rsp_result_d = alu_result;
               rsp_flags_d  = alu_flags;
               rsp_err_d    = 1'b0;
            end else begin
               rsp_result_d = 32'd0;
               rsp_flags_d  = 4'd0;
               rsp_err_d    = 1'b1;
            end
            state_d = ST_RESP;
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers. Reset leaves last_grant at 1 so port 0 wins the first
   // contention under round-robin.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         alu_op1_q    <= 32'd0;
         alu_op2_q    <= 32'd0;
         alu_field_q  <= 4'b0000;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 32'd0;
         rsp_flags_q  <= 4'd0;
         rsp_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_op1_q    <= alu_op1_d;
         alu_op2_q    <= alu_op2_d;
         alu_field_q  <= alu_field_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_op1    = alu_op1_q;
   assign alu_op2    = alu_op2_q;
   assign alu_field  = alu_field_q;
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. Two instances: dut (round-robin) and
// dut_fp (fixed priority). The bench models the external ALU and keeps a
// request-level reference model for the randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;

   // round-robin instance
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [3:0]  req0_field, req1_field;
   logic [31:0] alu_op1, alu_op2, alu_result;
   logic [3:0]  alu_field, alu_flags;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;

   // fixed-priority instance
   logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
   logic [31:0] fp_req0_op1, fp_req0_op2, fp_req1_op1, fp_req1_op2;
   logic [3:0]  fp_req0_field, fp_req1_field;
   logic [31:0] fp_alu_op1, fp_alu_op2, fp_alu_result;
   logic [3:0]  fp_alu_field, fp_alu_flags;
   logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_err, fp_busy;
   logic [31:0] fp_rsp_result;
   logic [3:0]  fp_rsp_flags;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [3:0] LEGAL [10] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                         4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};

   // Behavioural ALU, returns {flags, result}; flags = {carry, overflow, sign, zero}.
   // Unknown codes return junk so the arbiter must suppress it.
   function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
      logic [31:0] r;
      logic        c, v;
      r = 32'd0; c = 1'b0; v = 1'b0;
      case (f)
         4'b0000: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
         4'b1000: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
         4'b0111: r = a & b;
         4'b0110: r = a | b;
         4'b0100: r = a ^ b;
         4'b0001: r = a << b[4:0];
         4'b0101: r = a >> b[4:0];
         4'b1101: r = $signed(a) >>> b[4:0];
         4'b0010: r = {31'd0, $signed(a) < $signed(b)};
         4'b0011: r = {31'd0, a < b};
         default: return {4'hF, 32'hDEAD_BEEF};
      endcase
      return {c, v, r[31], (r == 32'd0), r};
   endfunction

   function automatic logic ref_legal(input logic [3:0] f);
      for (int i = 0; i < 10; i++) if (LEGAL[i] == f) return 1'b1;
      return 1'b0;
   endfunction

   assign {alu_flags, alu_result}       = ref_alu(alu_op1, alu_op2, alu_field);
   assign {fp_alu_flags, fp_alu_result} = ref_alu(fp_alu_op1, fp_alu_op2, fp_alu_field);

   alu_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
      .req0_op2(req0_op2), .req0_field(req0_field),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
      .req1_op2(req1_op2), .req1_field(req1_field),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_field(alu_field),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
   );

   alu_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op1(fp_req0_op1),
      .req0_op2(fp_req0_op2), .req0_field(fp_req0_field),
      .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op1(fp_req1_op1),
      .req1_op2(fp_req1_op2), .req1_field(fp_req1_field),
      .alu_op1(fp_alu_op1), .alu_op2(fp_alu_op2), .alu_field(fp_alu_field),
      .alu_result(fp_alu_result), .alu_flags(fp_alu_flags),
      .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id),
      .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err),
      .busy(fp_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL reset_valid_busy: got %b expected 00", {rsp_valid, busy}); else n_pass++;
      n_checks++; if ({alu_op1, alu_op2, alu_field} !== 68'd0) $display("FAIL reset_alu: got %h expected 0", {alu_op1, alu_op2, alu_field}); else n_pass++;
      n_checks++; if ({rsp_id, rsp_result, rsp_flags, rsp_err} !== 38'd0) $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_result, rsp_flags, rsp_err}); else n_pass++;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // One isolated operation on one port; C0 accept, C1 exec, C2 response.
   task automatic test_single_op(input int port, input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [3:0] field, input logic [31:0] exp_res,
                                 input logic [3:0] exp_flags, input logic exp_err, input string name);
      logic [1:0] exp_rdy;
      exp_rdy = (port == 1) ? 2'b10 : 2'b01;
      req0_valid = (port == 0); req0_op1 = op1; req0_op2 = op2; req0_field = field;
      req1_valid = (port == 1); req1_op1 = op1; req1_op2 = op2; req1_field = field;
      rsp_ready  = 1'b1;
      @(negedge clk);
      n_checks++; if ({req1_ready, req0_ready} !== exp_rdy) $display("FAIL %s_ready: got %b expected %b", name, {req1_ready, req0_ready}, exp_rdy); else n_pass++;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL %s_exec: got valid/busy %b expected 01", name, {rsp_valid, busy}); else n_pass++;
      n_checks++; if ({alu_op1, alu_op2, alu_field} !== {op1, op2, field}) $display("FAIL %s_alu_in: got %h expected %h", name, {alu_op1, alu_op2, alu_field}, {op1, op2, field}); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, port[0]}) $display("FAIL %s_rsp_id: got valid/id %b expected %b", name, {rsp_valid, rsp_id}, {1'b1, port[0]}); else n_pass++;
      n_checks++; if ({rsp_result, rsp_flags, rsp_err} !== {exp_res, exp_flags, exp_err}) $display("FAIL %s_rsp_data: got %h expected %h", name, {rsp_result, rsp_flags, rsp_err}, {exp_res, exp_flags, exp_err}); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL %s_done: got valid/busy %b expected 00", name, {rsp_valid, busy}); else n_pass++;
      tick();
   endtask

   // Both ports continuously valid on the round-robin instance.
   task automatic test_round_robin();
      int gid[$];
      int gcyc[$];
      req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_field = 4'b0000;
      req1_valid = 1'b1; req1_op1 = 32'd2; req1_op2 = 32'd2; req1_field = 4'b0000;
      rsp_ready  = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            gid.push_back(req1_ready ? 1 : 0);
            gcyc.push_back(cyc);
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_checks++; if (gid.size() != 4) $display("FAIL rr_count: got %0d grants expected 4", gid.size()); else n_pass++;
      for (int i = 0; i < gid.size() && i < 4; i++) begin
         n_checks++; if (gid[i] != i % 2) $display("FAIL rr_order[%0d]: got port %0d expected %0d", i, gid[i], i % 2); else n_pass++;
         n_checks++; if (gcyc[i] != 3 * i) $display("FAIL rr_cycle[%0d]: got cycle %0d expected %0d", i, gcyc[i], 3 * i); else n_pass++;
      end
   endtask

   task automatic test_fixed_priority();
      int n0, n1;
      n0 = 0; n1 = 0;
      fp_req0_valid = 1'b1; fp_req0_op1 = 32'd9; fp_req0_op2 = 32'd1; fp_req0_field = 4'b0000;
      fp_req1_valid = 1'b1; fp_req1_op1 = 32'd8; fp_req1_op2 = 32'd1; fp_req1_field = 4'b0000;
      fp_rsp_ready  = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clk);
         if (fp_req0_ready) begin
            n0++;
            n_checks++; if (cyc % 3 != 0) $display("FAIL fp_cycle: got grant at cycle %0d expected multiple of 3", cyc); else n_pass++;
         end
         if (fp_req1_ready) n1++;
         tick();
      end
      fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
      n_checks++; if (n0 != 3) $display("FAIL fp_port0_grants: got %0d expected 3", n0); else n_pass++;
      n_checks++; if (n1 != 0) $display("FAIL fp_port1_grants: got %0d expected 0", n1); else n_pass++;
   endtask

   // Response stalled 5 cycles while port 1 waits.
   task automatic test_backpressure();
      req0_valid = 1'b1; req0_op1 = 32'd7; req0_op2 = 32'd7; req0_field = 4'b1000;
      req1_valid = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL bp_accept0: got %b expected 1", req0_ready); else n_pass++;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op1 = 32'd10; req1_op2 = 32'd20; req1_field = 4'b0000;
      @(negedge clk);
      n_checks++; if ({rsp_valid, req1_ready} !== 2'b00) $display("FAIL bp_exec: got valid/ready1 %b expected 00", {rsp_valid, req1_ready}); else n_pass++;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req1_ready} !== {1'b1, 1'b0, 32'd0, 4'b0001, 1'b0})
            $display("FAIL bp_hold[%0d]: got %h expected %h", i, {rsp_valid, rsp_id, rsp_result, rsp_flags, req1_ready}, {1'b1, 1'b0, 32'd0, 4'b0001, 1'b0});
         else n_pass++;
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++; if ({rsp_valid, req1_ready} !== 2'b10) $display("FAIL bp_handshake: got valid/ready1 %b expected 10", {rsp_valid, req1_ready}); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if ({rsp_valid, req1_ready} !== 2'b01) $display("FAIL bp_accept1: got valid/ready1 %b expected 01", {rsp_valid, req1_ready}); else n_pass++;
      tick();
      req1_valid = 1'b0;
      tick();
      @(negedge clk);
      n_checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b1, 32'd30, 4'b0000}) $display("FAIL bp_rsp1: got %h expected %h", {rsp_valid, rsp_id, rsp_result, rsp_flags}, {1'b1, 1'b1, 32'd30, 4'b0000}); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      int stray;
      stray = 0;
      req1_valid = 1'b1; req1_op1 = 32'h1234; req1_op2 = 32'h10; req1_field = 4'b0000;
      rsp_ready  = 1'b1;
      @(negedge clk);
      n_checks++; if (req1_ready !== 1'b1) $display("FAIL rm_accept: got %b expected 1", req1_ready); else n_pass++;
      tick();
      req1_valid = 1'b0;
      #2;
      n_checks++; if ({busy, alu_op1} !== {1'b1, 32'h1234}) $display("FAIL rm_pre: got %h expected %h", {busy, alu_op1}, {1'b1, 32'h1234}); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL rm_async_vb: got %b expected 00", {rsp_valid, busy}); else n_pass++;
      n_checks++; if ({alu_op1, alu_op2, alu_field} !== 68'd0) $display("FAIL rm_async_alu: got %h expected 0", {alu_op1, alu_op2, alu_field}); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) stray++;
         tick();
      end
      n_checks++; if (stray != 0) $display("FAIL rm_no_rsp: got %0d active cycles expected 0", stray); else n_pass++;
      req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd4; req0_field = 4'b0000;
      req1_valid = 1'b1; req1_op1 = 32'd5; req1_op2 = 32'd6; req1_field = 4'b0000;
      @(negedge clk);
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rm_first_grant: got %b expected 01", {req1_ready, req0_ready}); else n_pass++;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      @(negedge clk);
      n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd7}) $display("FAIL rm_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd7}); else n_pass++;
      tick();
   endtask

   // Random traffic against a request-level model: one op in flight, response
   // two cycles after accept, arbitration rules applied to the pending requests.
   typedef struct {
      logic        id;
      logic [31:0] result;
      logic [3:0]  flags;
      logic        err;
   } rsp_t;

   task automatic test_random(input logic init_last);
      logic        p_valid [2];
      logic [31:0] p_op1 [2];
      logic [31:0] p_op2 [2];
      logic [3:0]  p_field [2];
      logic        model_last, outstanding, win, exp_vld;
      logic [1:0]  exp_rdy;
      int          acc_cyc;
      rsp_t        exp;
      model_last = init_last; outstanding = 1'b0; acc_cyc = 0;
      exp = '{id: 1'b0, result: 32'd0, flags: 4'd0, err: 1'b0};
      for (int p = 0; p < 2; p++) begin
         p_valid[p] = 1'b0; p_op1[p] = 32'd0; p_op2[p] = 32'd0; p_field[p] = 4'd0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!p_valid[p] && ($urandom_range(2) == 0)) begin
               p_valid[p] = 1'b1;
               p_op1[p]   = $urandom();
               p_op2[p]   = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom();
               p_field[p] = 4'($urandom_range(15));
            end
         end
         req0_valid = p_valid[0]; req0_op1 = p_op1[0]; req0_op2 = p_op2[0]; req0_field = p_field[0];
         req1_valid = p_valid[1]; req1_op1 = p_op1[1]; req1_op2 = p_op2[1]; req1_field = p_field[1];
         rsp_ready  = ($urandom_range(2) != 0);
         @(negedge clk);
         exp_rdy = 2'b00;
         win     = 1'b0;
         if (!outstanding && (p_valid[0] || p_valid[1])) begin
            win     = (p_valid[0] && p_valid[1]) ? !model_last : p_valid[1];
            exp_rdy = win ? 2'b10 : 2'b01;
         end
         exp_vld = outstanding && (cyc - acc_cyc >= 2);
         n_checks++; if ({req1_ready, req0_ready} !== exp_rdy) $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, {req1_ready, req0_ready}, exp_rdy); else n_pass++;
         n_checks++; if (rsp_valid !== exp_vld) $display("FAIL rnd_rsp_valid@%0d: got %b expected %b", cyc, rsp_valid, exp_vld); else n_pass++;
         if (exp_vld && rsp_ready) begin
            n_checks++;
            if ({rsp_id, rsp_result, rsp_flags, rsp_err} !== {exp.id, exp.result, exp.flags, exp.err})
               $display("FAIL rnd_rsp@%0d: got %h expected %h", cyc, {rsp_id, rsp_result, rsp_flags, rsp_err}, {exp.id, exp.result, exp.flags, exp.err});
            else n_pass++;
            outstanding = 1'b0;
         end
         if (exp_rdy != 2'b00) begin
            outstanding = 1'b1;
            acc_cyc     = cyc;
            model_last  = win;
            exp.id      = win;
            if (ref_legal(p_field[win])) begin
               {exp.flags, exp.result} = ref_alu(p_op1[win], p_op2[win], p_field[win]);
               exp.err = 1'b0;
            end else begin
               exp.flags = 4'd0; exp.result = 32'd0; exp.err = 1'b1;
            end
            p_valid[win] = 1'b0;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      req0_valid = 1'b0; req0_op1 = 32'd0; req0_op2 = 32'd0; req0_field = 4'd0;
      req1_valid = 1'b0; req1_op1 = 32'd0; req1_op2 = 32'd0; req1_field = 4'd0;
      rsp_ready  = 1'b0;
      fp_req0_valid = 1'b0; fp_req0_op1 = 32'd0; fp_req0_op2 = 32'd0; fp_req0_field = 4'd0;
      fp_req1_valid = 1'b0; fp_req1_op1 = 32'd0; fp_req1_op2 = 32'd0; fp_req1_field = 4'd0;
      fp_rsp_ready  = 1'b0;

      test_reset();
      test_single_op(0, 32'd5, 32'd3, 4'b0000, 32'd8, 4'b0000, 1'b0, "add_p0");
      test_single_op(1, 32'h8000_0000, 32'd1, 4'b1000, 32'h7FFF_FFFF, 4'b0100, 1'b0, "sub_ovf_p1");
      test_round_robin();
      test_backpressure();
      test_single_op(0, 32'd1, 32'd2, 4'b1001, 32'd0, 4'b0000, 1'b1, "illegal");
      test_fixed_priority();
      test_reset_mid();
      test_random(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters: port 0 is the execute stage, port 1 is the branch/auxiliary unit.
- Arbitrates with round-robin or fixed priority, then registers the winning operands onto the ALU inputs.
- Captures the ALU result and flags in the following cycle and returns them through a valid/ready response channel tagged with the requester id.
- One operation is in flight at a time.

Parameters:
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req0_valid  in  1  port 0 request valid.
req0_ready  out  1  port 0 request accepted this cycle.
req0_op1  in  32  port 0 operand 1.
req0_op2  in  32  port 0 operand 2.
req0_field  in  4  port 0 ALU field, {funct7[5]/0, funct3}.
req1_valid  in  1  port 1 request valid.
req1_ready  out  1  port 1 request accepted this cycle.
req1_op1  in  32  port 1 operand 1.
req1_op2  in  32  port 1 operand 2.
req1_field  in  4  port 1 ALU field.
alu_op1  out  32  registered ALU operand 1.
alu_op2  out  32  registered ALU operand 2.
alu_field  out  4  registered ALU field.
alu_result  in  32  ALU result.
alu_flags  in  4  ALU flags {carry, overflow, sign, zero}.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumer ready.
rsp_id  out  1  requester id of the response.
rsp_result  out  32  captured result.
rsp_flags  out  4  captured flags {carry, overflow, sign, zero}.
rsp_err  out  1  illegal field code.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - state=IDLE; all outputs 0.
  - alu_op1/op2=0, alu_field=4'b0000 (ADD).
  - last_grant=1, so port 0 wins the first contention.
- State machine:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE on rsp_valid && rsp_ready.
- Ready generation:
  - reqN_ready is combinational and high only in IDLE, and only for the winner; at most one ready is high.
  - It depends on the reqN_valid inputs and state only, never on rsp_ready.
- Winner selection:
  - If only one port is valid, that port wins.
  - If both are valid with RR_EN=1, the winner is !last_grant.
  - If both are valid with RR_EN=0, port 0 wins.
- Accept (valid && ready at the edge of cycle C0):
  - Latch the winner's op1/op2/field into alu_op1/alu_op2/alu_field.
  - Latch id; set last_grant=id; state=EXEC.
- EXEC (cycle C1):
  - The ALU evaluates the registered inputs.
  - At the end of C1, capture alu_result into rsp_result and alu_flags into rsp_flags; state=RESP.
- RESP (from cycle C2):
  - rsp_valid=1. rsp_valid, rsp_id, rsp_result, rsp_flags and rsp_err stay stable until rsp_ready.
  - On handshake: rsp_valid drops at the next edge; state=IDLE.
  - The earliest next accept is the cycle after the handshake, giving a minimum of 3 cycles per operation.
  - Latency is accept cycle C0 to rsp_valid in C2.
- alu_op1/op2/field hold their last latched values outside EXEC; they do not toggle in IDLE or RESP.
- Illegal fields:
  - Legal codes: 0000, 1000, 0111, 0110, 0100, 0001, 0101, 1101, 0010, 0011.
  - Any other code is still accepted and sequenced normally, but at capture: rsp_err=1, rsp_result=0, rsp_flags=0.
- Requester contract: a requester holds valid and payload stable until ready. The arbiter does not check this and samples only on accept.
- rsp_id is meaningful only while rsp_valid=1.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped and no response is produced after release. The requester reissues.
- rsp_ready high while not in RESP is ignored.
- Deasserting valid while not granted causes no side effect and does not update last_grant.

Test Plan:
1. Port 0 only, op1=5, op2=3, field=0000 -> req0_ready in C0, rsp_valid in C2, rsp_id=0, rsp_result=8, rsp_flags=0000, rsp_err=0.
2. Port 1 only, op1=32'h80000000, op2=1, field=1000 -> rsp_id=1, rsp_result=32'h7FFFFFFF, overflow flag=1, rsp_err=0.
3. Both ports continuously valid, rsp_ready=1:
   - RR_EN=1: grant order 0,1,0,1, with accepts exactly 3 cycles apart.
   - RR_EN=0: grant order 0,0,0; port 1 is never granted.
4. Port 0, op1=7, op2=7, field=1000, with rsp_ready held 0 for 5 cycles and req1_valid=1 -> rsp_valid, rsp_result=0 and zero flag=1 stay stable; req1_ready stays 0 throughout; port 1 is accepted the cycle after the rsp handshake.
5. field=4'b1001 with op1=1, op2=2 -> rsp_valid in C2 with rsp_err=1, rsp_result=0, rsp_flags=0000.
6. rst_n pulled low during EXEC -> rsp_valid, busy and alu_* go to 0 immediately without a clock edge; no response after release; the next contention grants port 0.
